register_param: RTL and testbench

REGISTER_PARAM -- requirements
Module: register_param

---
 rtl/register_param.sv | 106 ++++++++++
 tb/tb_register_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_param.sv
// Parameterised register: counter, shifter and loadable register bounded to 0..MAX_VAL.
// Define REGISTER_PARAM_SAT_EN to saturate at the bounds (adds the sat pulse output).
module register_param #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             shl,
    input  logic             shr,
    input  logic             sin,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             max,
    output logic             carry,
    output logic             borrow
`ifdef REGISTER_PARAM_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic             carry_d;
    logic             borrow_d;
`ifdef REGISTER_PARAM_SAT_EN
    logic             sat_d;
`endif

    always_comb begin
        shl_val  = {out[WIDTH-2:0], sin};
        shr_val  = {sin, out[WIDTH-1:1]};
        out_d    = out;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
`ifdef REGISTER_PARAM_SAT_EN
        sat_d    = 1'b0;
`endif
        if (clr) begin
            out_d = '0;
        end else if (ld) begin
            out_d = (in > MAX_VAL) ? MAX_VAL : in;
        end else if (inc && dec) begin
            // Opposing counts cancel and also mask any shift request.
            out_d = out;
        end else if (inc) begin
            if (out == MAX_VAL) begin
`ifdef REGISTER_PARAM_SAT_EN
                sat_d   = 1'b1;
`else
                out_d   = '0;
                carry_d = 1'b1;
`endif
            end else begin
                out_d = out + ONE;
            end
        end else if (dec) begin
            if (out == '0) begin
`ifdef REGISTER_PARAM_SAT_EN
                sat_d    = 1'b1;
`else
                out_d    = MAX_VAL;
                borrow_d = 1'b1;
`endif
            end else begin
                out_d = out - ONE;
            end
        end else if (shl) begin
            out_d = (shl_val > MAX_VAL) ? MAX_VAL : shl_val;
        end else if (shr) begin
            out_d = (shr_val > MAX_VAL) ? MAX_VAL : shr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= RESET_VAL;
            carry  <= 1'b0;
            borrow <= 1'b0;
`ifdef REGISTER_PARAM_SAT_EN
            sat    <= 1'b0;
`endif
        end else begin
            out    <= out_d;
            carry  <= carry_d;
            borrow <= borrow_d;
`ifdef REGISTER_PARAM_SAT_EN
            sat    <= sat_d;
`endif
        end
    end

    assign zero = (out == '0);
    assign max  = (out == MAX_VAL);

endmodule

// File: tb/tb_register_param.sv
// Self-checking bench for register_param: three instances with different MAX_VAL/RESET_VAL
// share one stimulus stream and are checked against a behavioural model of the bounded register.
module tb_register_param;

`ifdef REGISTER_PARAM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int unsigned MAXV[3] = '{255, 9, 200};
    localparam int unsigned RV[3]   = '{8'h5A, 0, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b0, clr = 1'b0, ld = 1'b0, inc = 1'b0, dec = 1'b0;
    logic       shl = 1'b0, shr = 1'b0, sin = 1'b0;
    logic [7:0] in_v = 8'h00;

    logic [7:0] d_out[3];
    logic       d_zero[3], d_max[3], d_carry[3], d_borrow[3];
`ifdef REGISTER_PARAM_SAT_EN
    logic       d_sat[3];
`endif

    int unsigned m_out[3];
    bit          m_carry[3], m_borrow[3], m_sat[3];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    register_param #(.WIDTH(8), .MAX_VAL(8'd255), .RESET_VAL(8'h5A)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .inc(inc), .dec(dec), .shl(shl), .shr(shr),
        .sin(sin), .in(in_v), .out(d_out[0]), .zero(d_zero[0]), .max(d_max[0]),
        .carry(d_carry[0]), .borrow(d_borrow[0])
`ifdef REGISTER_PARAM_SAT_EN
        , .sat(d_sat[0])
`endif
    );

    register_param #(.WIDTH(8), .MAX_VAL(8'd9), .RESET_VAL(8'd0)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .inc(inc), .dec(dec), .shl(shl), .shr(shr),
        .sin(sin), .in(in_v), .out(d_out[1]), .zero(d_zero[1]), .max(d_max[1]),
        .carry(d_carry[1]), .borrow(d_borrow[1])
`ifdef REGISTER_PARAM_SAT_EN
        , .sat(d_sat[1])
`endif
    );

    register_param #(.WIDTH(8), .MAX_VAL(8'd200), .RESET_VAL(8'd0)) u_c (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .inc(inc), .dec(dec), .shl(shl), .shr(shr),
        .sin(sin), .in(in_v), .out(d_out[2]), .zero(d_zero[2]), .max(d_max[2]),
        .carry(d_carry[2]), .borrow(d_borrow[2])
`ifdef REGISTER_PARAM_SAT_EN
        , .sat(d_sat[2])
`endif
    );

    // Bounded register semantics in plain integer arithmetic.
    function automatic void model_step(int i);
        int unsigned v;
        m_carry[i]  = 1'b0;
        m_borrow[i] = 1'b0;
        m_sat[i]    = 1'b0;
        if (rst) m_out[i] = RV[i];
        else if (clr) m_out[i] = 0;
        else if (ld) m_out[i] = (int'(in_v) > MAXV[i]) ? MAXV[i] : in_v;
        else if (inc && dec) m_out[i] = m_out[i];
        else if (inc) begin
            if (m_out[i] == MAXV[i]) begin
                if (SAT) m_sat[i] = 1'b1;
                else begin m_out[i] = 0; m_carry[i] = 1'b1; end
            end else m_out[i] = m_out[i] + 1;
        end else if (dec) begin
            if (m_out[i] == 0) begin
                if (SAT) m_sat[i] = 1'b1;
                else begin m_out[i] = MAXV[i]; m_borrow[i] = 1'b1; end
            end else m_out[i] = m_out[i] - 1;
        end else if (shl) begin
            v = (m_out[i] * 2) % 256 + (sin ? 1 : 0);
            m_out[i] = (v > MAXV[i]) ? MAXV[i] : v;
        end else if (shr) begin
            v = m_out[i] / 2 + (sin ? 128 : 0);
            m_out[i] = (v > MAXV[i]) ? MAXV[i] : v;
        end
    endfunction

    task automatic idle_inputs();
        rst = 0; clr = 0; ld = 0; inc = 0; dec = 0; shl = 0; shr = 0; sin = 0; in_v = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1; ld = 1; in_v = 8'hFF; inc = 1; shl = 1; sin = 1;
        tick();
        tests++; if (d_out[0] !== 8'h5A) begin
            fails++; $display("FAIL reset_out_a: got %0h want 5a", d_out[0]); end
        tests++; if (d_carry[0] !== 1'b0 || d_borrow[0] !== 1'b0) begin
            fails++; $display("FAIL reset_pulses_a: got c=%b b=%b want 0 0", d_carry[0], d_borrow[0]); end
        tests++; if (d_out[1] !== 8'h00 || d_zero[1] !== 1'b1) begin
            fails++; $display("FAIL reset_out_b: got %0h z=%b want 0 z=1", d_out[1], d_zero[1]); end
        tests++; if (d_zero[0] !== 1'b0 || d_max[0] !== 1'b0) begin
            fails++; $display("FAIL reset_flags_a: got z=%b m=%b want 0 0", d_zero[0], d_max[0]); end
    endtask

`ifndef REGISTER_PARAM_SAT_EN
    task automatic test_wrap();
        ld = 1; in_v = 8'd9;
        tick();
        tests++; if (d_out[1] !== 8'd9 || d_max[1] !== 1'b1) begin
            fails++; $display("FAIL wrap_load: got %0d max=%b want 9 max=1", d_out[1], d_max[1]); end
        inc = 1;
        tick();
        tests++; if (d_out[1] !== 8'd0 || d_carry[1] !== 1'b1 || d_zero[1] !== 1'b1) begin
            fails++; $display("FAIL wrap_inc: got %0d c=%b z=%b want 0 c=1 z=1",
                              d_out[1], d_carry[1], d_zero[1]); end
        tests++; if (d_out[0] !== 8'd10 || d_carry[0] !== 1'b0) begin
            fails++; $display("FAIL wrap_inc_a: got %0d c=%b want 10 c=0", d_out[0], d_carry[0]); end
        tick();
        tests++; if (d_carry[1] !== 1'b0 || d_out[1] !== 8'd0) begin
            fails++; $display("FAIL wrap_pulse_end: got %0d c=%b want 0 c=0", d_out[1], d_carry[1]); end
    endtask

    task automatic test_borrow();
        clr = 1;
        tick();
        dec = 1;
        tick();
        tests++; if (d_out[1] !== 8'd9 || d_borrow[1] !== 1'b1 || d_max[1] !== 1'b1) begin
            fails++; $display("FAIL borrow_dec: got %0d b=%b m=%b want 9 b=1 m=1",
                              d_out[1], d_borrow[1], d_max[1]); end
        tests++; if (d_out[0] !== 8'd255 || d_borrow[0] !== 1'b1 || d_carry[0] !== 1'b0) begin
            fails++; $display("FAIL borrow_dec_a: got %0d b=%b c=%b want 255 b=1 c=0",
                              d_out[0], d_borrow[0], d_carry[0]); end
        tick();
        tests++; if (d_borrow[1] !== 1'b0 || d_out[1] !== 8'd9) begin
            fails++; $display("FAIL borrow_pulse_end: got %0d b=%b want 9 b=0", d_out[1], d_borrow[1]); end
    endtask
`else
    task automatic test_saturation();
        ld = 1; in_v = 8'd9;
        tick();
        for (int k = 0; k < 3; k++) begin
            inc = 1;
            tick();
            tests++; if (d_out[1] !== 8'd9 || d_sat[1] !== 1'b1 || d_carry[1] !== 1'b0) begin
                fails++; $display("FAIL sat_inc_%0d: got %0d s=%b c=%b want 9 s=1 c=0",
                                  k, d_out[1], d_sat[1], d_carry[1]); end
        end
        clr = 1;
        tick();
        dec = 1;
        tick();
        tests++; if (d_out[1] !== 8'd0 || d_sat[1] !== 1'b1 || d_borrow[1] !== 1'b0) begin
            fails++; $display("FAIL sat_dec: got %0d s=%b b=%b want 0 s=1 b=0",
                              d_out[1], d_sat[1], d_borrow[1]); end
        tick();
        tests++; if (d_sat[1] !== 1'b0) begin
            fails++; $display("FAIL sat_pulse_end: got %b want 0", d_sat[1]); end
    endtask
`endif

    task automatic test_priority();
        ld = 1; in_v = 8'h10;
        tick();
        ld = 1; in_v = 8'h33; inc = 1; shl = 1;
        tick();
        tests++; if (d_out[0] !== 8'h33 || d_out[1] !== 8'd9) begin
            fails++; $display("FAIL prio_ld: got a=%0h b=%0d want 33 9", d_out[0], d_out[1]); end
        inc = 1; dec = 1; shl = 1; sin = 1;
        tick();
        tests++; if (d_out[0] !== 8'h33) begin
            fails++; $display("FAIL prio_incdec: got %0h want 33", d_out[0]); end
        tests++; if (d_carry[1] !== 1'b0 || d_borrow[1] !== 1'b0) begin
            fails++; $display("FAIL prio_no_pulse: got c=%b b=%b want 0 0", d_carry[1], d_borrow[1]); end
        clr = 1; ld = 1; in_v = 8'h44;
        tick();
        tests++; if (d_out[0] !== 8'h00) begin
            fails++; $display("FAIL prio_clr: got %0h want 0", d_out[0]); end
    endtask

    task automatic test_shift();
        ld = 1; in_v = 8'h64;
        tick();
        shl = 1; sin = 1; shr = 1;
        tick();
        tests++; if (d_out[2] !== 8'd200 || d_max[2] !== 1'b1) begin
            fails++; $display("FAIL shl_clamp: got %0d m=%b want 200 m=1", d_out[2], d_max[2]); end
        tests++; if (d_out[0] !== 8'hC9) begin
            fails++; $display("FAIL shl_a: got %0h want c9", d_out[0]); end
        shr = 1; sin = 0;
        tick();
        tests++; if (d_out[2] !== 8'h64) begin
            fails++; $display("FAIL shr_c: got %0h want 64", d_out[2]); end
        shr = 1; sin = 1;
        tick();
        tests++; if (d_out[0] !== 8'hB2) begin
            fails++; $display("FAIL shr_sin_a: got %0h want b2", d_out[0]); end
    endtask

    task automatic test_rst_abort();
        ld = 1; in_v = 8'd9;
        tick();
        rst = 1; inc = 1;
        tick();
        tests++; if (d_out[1] !== 8'd0 || d_carry[1] !== 1'b0) begin
            fails++; $display("FAIL abort_b: got %0d c=%b want 0 c=0", d_out[1], d_carry[1]); end
        tests++; if (d_out[0] !== 8'h5A) begin
            fails++; $display("FAIL abort_a: got %0h want 5a", d_out[0]); end
        tick();
        tests++; if (d_carry[1] !== 1'b0 || d_borrow[1] !== 1'b0) begin
            fails++; $display("FAIL abort_late: got c=%b b=%b want 0 0", d_carry[1], d_borrow[1]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(31) == 0);
            clr  = ($urandom_range(15) == 0);
            ld   = ($urandom_range(7) == 0);
            inc  = $urandom_range(1);
            dec  = $urandom_range(1);
            shl  = $urandom_range(1);
            shr  = $urandom_range(1);
            sin  = $urandom_range(1);
            in_v = 8'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                tests++; if (d_out[i] !== 8'(m_out[i])) begin
                    fails++; $display("FAIL rand_out[%0d] n=%0d: got %0d want %0d",
                                      i, n, d_out[i], m_out[i]); end
                tests++; if (d_zero[i] !== (m_out[i] == 0) || d_max[i] !== (m_out[i] == MAXV[i]))
                begin
                    fails++; $display("FAIL rand_flags[%0d] n=%0d: got z=%b m=%b", i, n,
                                      d_zero[i], d_max[i]); end
                tests++; if (d_carry[i] !== m_carry[i] || d_borrow[i] !== m_borrow[i]) begin
                    fails++; $display("FAIL rand_pulse[%0d] n=%0d: got c=%b b=%b want c=%b b=%b",
                                      i, n, d_carry[i], d_borrow[i], m_carry[i], m_borrow[i]); end
`ifdef REGISTER_PARAM_SAT_EN
                tests++; if (d_sat[i] !== m_sat[i]) begin
                    fails++; $display("FAIL rand_sat[%0d] n=%0d: got %b want %b",
                                      i, n, d_sat[i], m_sat[i]); end
`endif
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_out[i] = RV[i]; m_carry[i] = 0; m_borrow[i] = 0; m_sat[i] = 0;
        end
        @(negedge clk);
        test_reset();
`ifndef REGISTER_PARAM_SAT_EN
        test_wrap();
        test_borrow();
`else
        test_saturation();
`endif
        test_priority();
        test_shift();
        test_rst_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
